fft8_stream_ctrl: RTL and testbench

Frame sequencer that sits in front of `fft8_top` and converts it into a streaming block. It accepts N complex samples on a valid/ready input stream and writes them into the FFT register file at bit-reversed addresses. It then pulses `start`, waits for `done`, and reads all N bins back in natural order onto a valid/ready output stream. Frames are processed back-to-back with no software involvement.

---
 rtl/fft8_stream_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fft8_stream_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_stream_ctrl.sv
// Streaming front end for fft8_top: loads one frame at bit-reversed addresses,
// runs the transform, then unloads the bins in natural order.
module fft8_stream_ctrl #(
    parameter int unsigned N     = 8,
    parameter int unsigned WIDTH = 12,
    parameter int unsigned AW    = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_re,
    input  logic signed [WIDTH-1:0] s_im,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_re,
    output logic signed [WIDTH-1:0] m_im,
    output logic                    m_last,
    output logic                    fft_load,
    output logic [AW-1:0]           fft_load_addr,
    output logic signed [WIDTH-1:0] fft_in_re,
    output logic signed [WIDTH-1:0] fft_in_im,
    output logic                    fft_start,
    input  logic                    fft_done,
    output logic [AW-1:0]           fft_out_addr,
    input  logic signed [WIDTH-1:0] fft_out_re,
    input  logic signed [WIDTH-1:0] fft_out_im,
    output logic                    busy
);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        FLUSH = 3'd1,
        START = 3'd2,
        GUARD = 3'd3,
        WAIT  = 3'd4,
        ADDR  = 3'd5,
        OUT   = 3'd6
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [AW-1:0]             cnt;
    logic [AW-1:0]             cnt_nxt;
    logic                      fft_load_nxt;
    logic [AW-1:0]             fft_load_addr_nxt;
    logic signed [WIDTH-1:0]   fft_in_re_nxt;
    logic signed [WIDTH-1:0]   fft_in_im_nxt;
    logic                      fft_start_nxt;
    logic [AW-1:0]             fft_out_addr_nxt;
    logic                      m_valid_nxt;
    logic                      m_last_nxt;
    logic signed [WIDTH-1:0]   m_re_nxt;
    logic signed [WIDTH-1:0]   m_im_nxt;

    // Sample index -> register-file address for a decimation-in-time core
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(AW); i++) begin
            r[i] = a[int'(AW) - 1 - i];
        end
        return r;
    endfunction

    assign s_ready = (state == LOAD);
    assign busy    = !((state == LOAD) && (cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LOAD;
            cnt           <= '0;
            fft_load      <= 1'b0;
            fft_load_addr <= '0;
            fft_in_re     <= '0;
            fft_in_im     <= '0;
            fft_start     <= 1'b0;
            fft_out_addr  <= '0;
            m_valid       <= 1'b0;
            m_last        <= 1'b0;
            m_re          <= '0;
            m_im          <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            fft_load      <= fft_load_nxt;
            fft_load_addr <= fft_load_addr_nxt;
            fft_in_re     <= fft_in_re_nxt;
            fft_in_im     <= fft_in_im_nxt;
            fft_start     <= fft_start_nxt;
            fft_out_addr  <= fft_out_addr_nxt;
            m_valid       <= m_valid_nxt;
            m_last        <= m_last_nxt;
            m_re          <= m_re_nxt;
            m_im          <= m_im_nxt;
        end
    end

    // Next-state and next-value logic; every output register is fed from here
    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        fft_load_nxt      = 1'b0;
        fft_load_addr_nxt = fft_load_addr;
        fft_in_re_nxt     = fft_in_re;
        fft_in_im_nxt     = fft_in_im;
        fft_start_nxt     = 1'b0;
        fft_out_addr_nxt  = fft_out_addr;
        m_valid_nxt       = m_valid;
        m_last_nxt        = m_last;
        m_re_nxt          = m_re;
        m_im_nxt          = m_im;

        case (state)
            LOAD: begin
                if (s_valid) begin
                    fft_load_nxt      = 1'b1;
                    fft_load_addr_nxt = bitrev(cnt);
                    fft_in_re_nxt     = s_re;
                    fft_in_im_nxt     = s_im;
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = FLUSH;
                    end else begin
                        cnt_nxt = cnt + AW'(1);
                    end
                end
            end
            FLUSH: begin
                // Registered start lands in the START cycle
                fft_start_nxt = 1'b1;
                state_nxt     = START;
            end
            START: begin
                state_nxt = GUARD;
            end
            GUARD: begin
                // done may still be high from the previous frame here
                state_nxt = WAIT;
            end
            WAIT: begin
                if (fft_done) begin
                    fft_out_addr_nxt = '0;
                    state_nxt        = ADDR;
                end
            end
            ADDR: begin
                m_re_nxt    = fft_out_re;
                m_im_nxt    = fft_out_im;
                m_valid_nxt = 1'b1;
                m_last_nxt  = (fft_out_addr == LAST);
                state_nxt   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_nxt = 1'b0;
                    if (fft_out_addr != LAST) begin
                        fft_out_addr_nxt = fft_out_addr + AW'(1);
                        state_nxt        = ADDR;
                    end else begin
                        m_last_nxt = 1'b0;
                        state_nxt  = LOAD;
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_fft8_stream_ctrl.sv
// Directed bench for fft8_stream_ctrl with a behavioral fft8_top stand-in.
module tb_fft8_stream_ctrl;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned AW    = 3;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_re;
    logic [WIDTH-1:0] s_im;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_re;
    logic [WIDTH-1:0] m_im;
    logic             m_last;
    logic             fft_load;
    logic [AW-1:0]    fft_load_addr;
    logic [WIDTH-1:0] fft_in_re;
    logic [WIDTH-1:0] fft_in_im;
    logic             fft_start;
    logic             fft_done;
    logic [AW-1:0]    fft_out_addr;
    logic [WIDTH-1:0] fft_out_re;
    logic [WIDTH-1:0] fft_out_im;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int stale_hold = 0;
    int dcnt       = 0;
    int clr_cnt    = 0;

    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [AW-1:0]    ld_addr_q [$];
    logic [WIDTH-1:0] ld_re_q   [$];
    logic [WIDTH-1:0] ld_im_q   [$];
    logic [WIDTH-1:0] out_re_q  [$];
    logic [WIDTH-1:0] out_im_q  [$];
    logic             out_last_q[$];
    int               out_cyc_q [$];
    int acc_cyc         = 0;
    int start_total     = 0;
    int start_cyc       = 0;
    int done_rise_cyc   = 0;
    int sready_rise_cyc = 0;
    logic prev_done     = 1'b0;
    logic prev_sready   = 1'b0;

    int lb;
    int ob;
    int sb;
    int w;

    fft8_stream_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_re          (s_re),
        .s_im          (s_im),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_re          (m_re),
        .m_im          (m_im),
        .m_last        (m_last),
        .fft_load      (fft_load),
        .fft_load_addr (fft_load_addr),
        .fft_in_re     (fft_in_re),
        .fft_in_im     (fft_in_im),
        .fft_start     (fft_start),
        .fft_done      (fft_done),
        .fft_out_addr  (fft_out_addr),
        .fft_out_re    (fft_out_re),
        .fft_out_im    (fft_out_im),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // fft8_top stand-in: done rises 10+ cycles after start, optionally stays stale one cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fft_done <= 1'b0;
            dcnt     <= 0;
            clr_cnt  <= 0;
        end else if (fft_start) begin
            dcnt    <= 10;
            clr_cnt <= stale_hold;
            if (stale_hold == 0) fft_done <= 1'b0;
        end else begin
            if (clr_cnt == 1) fft_done <= 1'b0;
            if (clr_cnt > 0) clr_cnt <= clr_cnt - 1;
            if (dcnt == 1) fft_done <= 1'b1;
            if (dcnt > 0) dcnt <= dcnt - 1;
        end
    end

    assign fft_out_re = {{(WIDTH-AW){1'b0}}, fft_out_addr};
    assign fft_out_im = {{(WIDTH-AW){1'b0}}, fft_out_addr} + WIDTH'(8);

    // Observe one time unit before each rising edge
    always @(negedge clk) begin
        #4;
        if (s_valid && s_ready) acc_cyc = cyc;
        if (fft_load) begin
            ld_addr_q.push_back(fft_load_addr);
            ld_re_q.push_back(fft_in_re);
            ld_im_q.push_back(fft_in_im);
        end
        if (fft_start) begin
            start_total = start_total + 1;
            start_cyc   = cyc;
        end
        if (fft_done && !prev_done) done_rise_cyc = cyc;
        if (s_ready && !prev_sready) sready_rise_cyc = cyc;
        if (m_valid && m_ready) begin
            out_re_q.push_back(m_re);
            out_im_q.push_back(m_im);
            out_last_q.push_back(m_last);
            out_cyc_q.push_back(cyc);
        end
        prev_done   = fft_done;
        prev_sready = s_ready;
    end

    function automatic logic [31:0] w12(input int v);
        logic [31:0] t;
        t = v;
        return {20'd0, t[11:0]};
    endfunction

    function automatic int samp_re(input int kind, input int i);
        if (kind == 0) return (i == 0) ? 256 : 0;
        return 16 * kind + i;
    endfunction

    function automatic int samp_im(input int kind, input int i);
        if (kind == 0) return 0;
        return -(16 * kind + i + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_m_re"}, 32'(m_re), 32'd0);
        check({tag, "_m_im"}, 32'(m_im), 32'd0);
        check({tag, "_fft_load"}, 32'(fft_load), 32'd0);
        check({tag, "_load_addr"}, 32'(fft_load_addr), 32'd0);
        check({tag, "_in_re"}, 32'(fft_in_re), 32'd0);
        check({tag, "_in_im"}, 32'(fft_in_im), 32'd0);
        check({tag, "_start"}, 32'(fft_start), 32'd0);
        check({tag, "_out_addr"}, 32'(fft_out_addr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic send_frame(input int n, input bit gaps, input int kind);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            int wt;
            wt = 0;
            @(negedge clk);
            while (!s_ready && wt < 100) begin
                @(negedge clk);
                wt = wt + 1;
            end
            if (!s_ready) check("send_s_ready", 32'(s_ready), 32'd1);
            t = w12(samp_re(kind, i));
            s_re = t[11:0];
            t = w12(samp_im(kind, i));
            s_im = t[11:0];
            s_valid = 1'b1;
            if (gaps) begin
                @(negedge clk);
                s_valid = 1'b0;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int base, input string tag);
        int wt;
        wt = 0;
        while (out_re_q.size() < base + 8 && wt < 400) begin
            @(negedge clk);
            wt = wt + 1;
        end
        check({tag, "_out_count"}, 32'(out_re_q.size() - base), 32'd8);
    endtask

    task automatic check_loads(input int base, input int kind, input string tag);
        check({tag, "_load_count"}, 32'(ld_addr_q.size() - base), 32'd8);
        for (int j = 0; j < 8; j++) begin
            int idx;
            idx = base + j;
            if (idx < ld_addr_q.size()) begin
                check($sformatf("%s_ld_addr%0d", tag, j), 32'(ld_addr_q[idx]), 32'(br[j]));
                check($sformatf("%s_ld_re%0d", tag, j), 32'(ld_re_q[idx]), w12(samp_re(kind, j)));
                check($sformatf("%s_ld_im%0d", tag, j), 32'(ld_im_q[idx]), w12(samp_im(kind, j)));
            end else begin
                check($sformatf("%s_ld_missing%0d", tag, j), 32'(idx), 32'(ld_addr_q.size()));
            end
        end
    endtask

    task automatic check_outputs(input int base, input string tag);
        for (int j = 0; j < 8; j++) begin
            int idx;
            idx = base + j;
            if (idx < out_re_q.size()) begin
                check($sformatf("%s_m_re%0d", tag, j), 32'(out_re_q[idx]), 32'(j));
                check($sformatf("%s_m_im%0d", tag, j), 32'(out_im_q[idx]), 32'(j + 8));
                check($sformatf("%s_m_last%0d", tag, j), 32'(out_last_q[idx]), (j == 7) ? 32'd1 : 32'd0);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_re    = '0;
        s_im    = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        check("por_s_ready_after", 32'(s_ready), 32'd1);

        // Impulse frame, streams tied high
        m_ready = 1'b1;
        lb = ld_addr_q.size();
        ob = out_re_q.size();
        sb = start_total;
        send_frame(8, 1'b0, 0);
        wait_outputs(ob, "f1");
        check_loads(lb, 0, "f1");
        check_outputs(ob, "f1");
        check("f1_start_pulses", 32'(start_total - sb), 32'd1);
        check("f1_start_lat", 32'(start_cyc - acc_cyc), 32'd2);
        check("f1_first_out_lat", 32'(out_cyc_q[ob] - done_rise_cyc), 32'd2);
        check("f1_unload_span", 32'(out_cyc_q[ob + 7] - out_cyc_q[ob]), 32'd14);

        // Input gaps: s_valid alternates 1/0
        lb = ld_addr_q.size();
        ob = out_re_q.size();
        send_frame(8, 1'b1, 2);
        wait_outputs(ob, "f2");
        check_loads(lb, 2, "f2");
        check_outputs(ob, "f2");

        // Output backpressure on bin 3
        ob = out_re_q.size();
        send_frame(8, 1'b0, 3);
        w = 0;
        while (!(m_valid && m_re == WIDTH'(3)) && w < 200) begin
            @(negedge clk);
            w = w + 1;
        end
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("f3_hold%0d", k), {4'd0, m_valid, m_re, m_im, fft_out_addr},
                  {4'd0, 1'b1, 12'd3, 12'd11, 3'd3});
        end
        m_ready = 1'b1;
        wait_outputs(ob, "f3");
        check_outputs(ob, "f3");

        // Stale done held one cycle past start
        stale_hold = 1;
        ob = out_re_q.size();
        send_frame(8, 1'b0, 4);
        wait_outputs(ob, "f4");
        check_outputs(ob, "f4");
        check("f4_done_after_start", 32'(done_rise_cyc > start_cyc), 32'd1);
        check("f4_first_out_lat", 32'(out_cyc_q[ob] - done_rise_cyc), 32'd2);
        stale_hold = 0;

        // Reset while waiting for done
        ob = out_re_q.size();
        send_frame(8, 1'b0, 5);
        w = 0;
        while (!fft_start && w < 20) begin
            @(negedge clk);
            w = w + 1;
        end
        check("f5_start_seen", 32'(fft_start), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("rst_wait");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wait_s_ready_after", 32'(s_ready), 32'd1);

        // Reset after 5 accepts, then a full frame
        send_frame(5, 1'b0, 6);
        @(negedge clk);
        check("f6_busy_partial", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("f6_busy_after_rst", 32'(busy), 32'd0);
        check("f5_no_outputs", 32'(out_re_q.size()), 32'(ob));
        lb = ld_addr_q.size();
        send_frame(8, 1'b0, 6);
        wait_outputs(ob, "f6");
        check_loads(lb, 6, "f6");
        check_outputs(ob, "f6");

        // Back-to-back frame right after m_last
        sb = ob;
        lb = ld_addr_q.size();
        ob = out_re_q.size();
        send_frame(8, 1'b0, 7);
        check("f7_s_ready_rise", 32'(sready_rise_cyc - out_cyc_q[sb + 7]), 32'd1);
        wait_outputs(ob, "f7");
        check_loads(lb, 7, "f7");
        check_outputs(ob, "f7");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
